div_32x16: RTL and testbench

DIV_32X16 -- requirements
Module: div_32x16

---
 rtl/div_32x16.sv | 108 ++++++++++
 tb/tb_div_32x16.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_32x16.sv
// Sequential restoring divider: 32-bit unsigned dividend by 16-bit unsigned divisor.
// One quotient bit per clock, 33 clocks per result; divide-by-zero completes in 1 clock.
module div_32x16 #(
   parameter int DATA_W = 32,
   parameter int COEF_W = 16,
   parameter int STAGES = DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] dividend,
   input  logic [COEF_W-1:0] divisor,
   output logic [DATA_W-1:0] quotient,
   output logic [COEF_W-1:0] remainder,
   output logic              div_zero,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STAGES - 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] q;
   logic [COEF_W:0]   r;
   logic [COEF_W-1:0] dvs;
   logic              zflag;

   logic              load, iter, fin;
   logic [COEF_W:0]   t, diff;
   logic              ge;

   // The partial remainder is always below the divisor, so its top bit stays clear.
   logic              unused_r_msb;
   assign unused_r_msb = r[COEF_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (divisor == '0) ? FINISH : CALC;
         CALC:    if (cnt == LAST) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load = 1'b0;
      iter = 1'b0;
      fin  = 1'b0;
      case (state)
         IDLE:    load = start;
         CALC:    iter = 1'b1;
         FINISH:  fin  = 1'b1;
         default: ;
      endcase
   end

   assign t    = {r[COEF_W-1:0], q[DATA_W-1]};
   assign ge   = (t >= {1'b0, dvs});
   assign diff = t - {1'b0, dvs};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= '0;
         q         <= '0;
         r         <= '0;
         dvs       <= '0;
         zflag     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            cnt   <= '0;
            q     <= dividend;
            r     <= '0;
            dvs   <= divisor;
            zflag <= (divisor == '0);
            busy  <= 1'b1;
         end
         if (iter) begin
            cnt <= cnt + 1'b1;
            q   <= {q[DATA_W-2:0], ge};
            r   <= ge ? diff : t;
         end
         // On divide-by-zero q still holds the untouched dividend.
         if (fin) begin
            quotient  <= zflag ? '1 : q;
            remainder <= zflag ? q[COEF_W-1:0] : r[COEF_W-1:0];
            div_zero  <= zflag;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div_32x16.sv
// Scoreboard bench for div_32x16: expected results queued at launch, compared at done.
module tb_div_32x16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_zero, busy, done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] q;
      logic [15:0] r;
      logic        z;
   } exp_t;

   exp_t sb[$];

   div_32x16 dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] dd, input logic [15:0] dv, input bit push);
      exp_t e;
      if (dv == 16'h0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = dd[15:0];
         e.z = 1'b1;
      end else begin
         e.q = dd / {16'h0, dv};
         e.r = 16'(dd % {16'h0, dv});
         e.z = 1'b0;
      end
      if (push) sb.push_back(e);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      tick();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
   endtask

   task automatic await(input int n0, input int exp_lat, input string name);
      int n;
      exp_t e;
      n = n0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (n != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got empty queue expected one entry", name);
      end else begin
         e = sb.pop_front();
         checks++;
         if (quotient !== e.q) begin
            errors++;
            $display("FAIL %s quotient: got %h expected %h", name, quotient, e.q);
         end
         checks++;
         if (remainder !== e.r) begin
            errors++;
            $display("FAIL %s remainder: got %h expected %h", name, remainder, e.r);
         end
         checks++;
         if (div_zero !== e.z) begin
            errors++;
            $display("FAIL %s div_zero: got %b expected %b", name, div_zero, e.z);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
      end
   endtask

   task automatic check_pulse_end(input string name);
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s done_width: got %b expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if ({quotient, remainder, div_zero, busy, done} !== 51'h0) begin
         errors++;
         $display("FAIL reset_outputs: got q=%h r=%h z=%b b=%b d=%b expected all 0",
                  quotient, remainder, div_zero, busy, done);
      end
      reset = 1'b1;
      launch(32'd5, 16'd2, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL first_start_after_reset busy: got %b expected 1", busy);
      end
      await(0, 33, "post_reset_5_2");
      check_pulse_end("post_reset_5_2");
   endtask

   task automatic test_basic();
      launch(32'd1000, 16'd7, 1'b1);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_after_E0: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      await(0, 33, "1000_div_7");
      checks++;
      if (quotient !== 32'd142 || remainder !== 16'd6) begin
         errors++;
         $display("FAIL 1000_div_7 literal: got q=%0d r=%0d expected q=142 r=6", quotient, remainder);
      end
      check_pulse_end("1000_div_7");
   endtask

   task automatic test_boundaries();
      launch(32'hFFFF_FFFF, 16'h0001, 1'b1);
      await(0, 33, "max_div_1");
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 16'h0) begin
         errors++;
         $display("FAIL max_div_1 literal: got q=%h r=%h expected q=ffffffff r=0000", quotient, remainder);
      end
      check_pulse_end("max_div_1");
      launch(32'h1234_5678, 16'hFFFF, 1'b1);
      await(0, 33, "div_ffff");
      checks++;
      if (quotient !== 32'h0000_1234 || remainder !== 16'h68AC) begin
         errors++;
         $display("FAIL div_ffff literal: got q=%h r=%h expected q=00001234 r=68ac", quotient, remainder);
      end
      check_pulse_end("div_ffff");
   endtask

   task automatic test_div_zero();
      launch(32'h0000_ABCD, 16'h0, 1'b1);
      await(0, 1, "div_zero");
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 16'hABCD || div_zero !== 1'b1) begin
         errors++;
         $display("FAIL div_zero literal: got q=%h r=%h z=%b expected q=ffffffff r=abcd z=1",
                  quotient, remainder, div_zero);
      end
      check_pulse_end("div_zero");
      repeat (5) tick();
      checks++;
      if (quotient !== 32'hFFFF_FFFF || remainder !== 16'hABCD || div_zero !== 1'b1) begin
         errors++;
         $display("FAIL div_zero_hold: got q=%h r=%h z=%b expected q=ffffffff r=abcd z=1",
                  quotient, remainder, div_zero);
      end
   endtask

   task automatic test_start_ignored();
      launch(32'd50000, 16'd3, 1'b1);
      repeat (9) tick();
      start    = 1'b1;
      dividend = 32'd999;
      divisor  = 16'd0;
      tick();
      start = 1'b0;
      await(10, 33, "start_ignored");
      launch(32'd77, 16'd5, 1'b1);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL start_after_done: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      await(0, 33, "start_after_done");
      check_pulse_end("start_after_done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] dd;
      logic [15:0] dv;
      for (int i = 0; i < 6; i++) begin
         dd = $urandom;
         dv = (i == 2) ? 16'h0 : ((i % 2 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom));
         if (dv == 16'h0 && i != 2) dv = 16'h3;
         launch(dd, dv, 1'b1);
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d busy: got %b expected 1", i, busy);
         end
         await(0, (dv == 16'h0) ? 1 : 33, $sformatf("b2b_%0d", i));
      end
      check_pulse_end("b2b_last");
   endtask

   task automatic test_reset_mid();
      int seen;
      launch(32'd123456, 16'd11, 1'b0);
      repeat (14) tick();
      @(posedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({quotient, remainder, div_zero, busy, done} !== 51'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got q=%h r=%h z=%b b=%b d=%b expected all 0",
                  quotient, remainder, div_zero, busy, done);
      end
      repeat (2) tick();
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", seen);
      end
      launch(32'd100, 16'd10, 1'b1);
      await(0, 33, "100_div_10");
      checks++;
      if (quotient !== 32'd10 || remainder !== 16'd0) begin
         errors++;
         $display("FAIL 100_div_10 literal: got q=%0d r=%0d expected q=10 r=0", quotient, remainder);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
